// File: rtl/ic_pkg.sv
// ic_pkg -- shared definitions for the CU backup/restore controller.
//   ic_bk_state_e : controller FSM states
//   IC_N_REGS     : default number of CU pipeline control registers
//   IC_BASE_ADDR  : default NVM word address of register 0
package ic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BK_SEL,
    BK_WR,
    BK_ACK,
    RS_RD,
    RS_APPLY,
    DONE
  } ic_bk_state_e;

  localparam int IC_N_REGS    = 3;
  localparam int IC_BASE_ADDR = 0;

endpackage

// File: rtl/cu_backup_ctrl.sv
// cu_backup_ctrl -- backs up dirty CU pipeline control registers to NVM on a
// supply-low warning, and restores all of them from NVM on power-up.
//
// Ports
//   Clk, Rst            clock, synchronous active-low reset
//   Pwr_warn            supply-low warning, starts a backup (wins over restore)
//   Restore_req         power-up restore request
//   dirty_vals_cu       per-register status, bit 2i = register i dirty
//   backup_Vouts_cu     per-register backup data, slice i at [i*W +: W]
//   backup_ens_cu       one-hot backup enable, held while register i is written
//   backup_acks_cu      one-cycle pulse when register i's write is acknowledged
//   restore_ens_cu      one-cycle load pulse for register i
//   restore_Vins_cu     restored word, replicated on every slice
//   nvm_*               single-outstanding NVM request/ack port
//   stand_by            pipeline freeze, high in every non-IDLE state
//   Bk_done, Rs_done    sequence complete, held until the request drops
module cu_backup_ctrl
  import ic_pkg::*;
#(
  parameter int N_REGS    = IC_N_REGS,
  parameter int W         = 32,
  parameter int AW        = 8,
  parameter int BASE_ADDR = IC_BASE_ADDR
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Pwr_warn,
  input  logic                Restore_req,
  input  logic [2*N_REGS-1:0] dirty_vals_cu,
  input  logic [W*N_REGS-1:0] backup_Vouts_cu,
  output logic [N_REGS-1:0]   backup_ens_cu,
  output logic [N_REGS-1:0]   backup_acks_cu,
  output logic [N_REGS-1:0]   restore_ens_cu,
  output logic [W*N_REGS-1:0] restore_Vins_cu,
  output logic                nvm_req,
  output logic                nvm_we,
  output logic [AW-1:0]       nvm_addr,
  output logic [W-1:0]        nvm_wdata,
  input  logic                nvm_ack,
  input  logic [W-1:0]        nvm_rdata,
  output logic                stand_by,
  output logic                Bk_done,
  output logic                Rs_done
);

  localparam int            IW   = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_REGS - 1);

  ic_bk_state_e        state_q;
  logic [IW-1:0]       idx_q;
  logic                bk_mode_q;   // 1: sequence started by Pwr_warn
  logic                abort_q;     // Pwr_warn seen during a restore
  logic [N_REGS-1:0]   bk_ens_q, bk_acks_q, rs_ens_q;
  logic [W*N_REGS-1:0] rs_vins_q;
  logic                req_q, we_q;
  logic [AW-1:0]       addr_q;
  logic [W-1:0]        wdata_q;
  logic                stand_by_q, bk_done_q, rs_done_q;

  logic [N_REGS-1:0]   dirty;
  logic [N_REGS-1:0]   unused_odd;
  logic [W-1:0]        bk_slice [N_REGS];
  logic                abort_now;

  always_comb begin
    dirty      = '0;
    unused_odd = '0;
    for (int i = 0; i < N_REGS; i++) begin
      dirty[i]      = dirty_vals_cu[2*i];
      unused_odd[i] = dirty_vals_cu[2*i+1];
      bk_slice[i]   = backup_Vouts_cu[i*W +: W];
    end
  end

  // A short Pwr_warn pulse is latched in abort_q so it is not lost while a
  // read is still waiting for its ack.
  assign abort_now = abort_q | Pwr_warn;

  function automatic logic [AW-1:0] addr_of(input logic [IW-1:0] i);
    return AW'(BASE_ADDR) + AW'(i);
  endfunction

  function automatic logic [N_REGS-1:0] onehot(input logic [IW-1:0] i);
    return N_REGS'(1) << i;
  endfunction

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      bk_mode_q  <= 1'b0;
      abort_q    <= 1'b0;
      bk_ens_q   <= '0;
      bk_acks_q  <= '0;
      rs_ens_q   <= '0;
      rs_vins_q  <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      stand_by_q <= 1'b0;
      bk_done_q  <= 1'b0;
      rs_done_q  <= 1'b0;
    end else begin
      // ack and load outputs are single-cycle pulses
      bk_acks_q <= '0;
      rs_ens_q  <= '0;
      unique case (state_q)
        IDLE: begin
          idx_q   <= '0;
          abort_q <= 1'b0;
          if (Pwr_warn) begin
            state_q    <= BK_SEL;
            bk_mode_q  <= 1'b1;
            stand_by_q <= 1'b1;
          end else if (Restore_req) begin
            state_q    <= RS_RD;
            bk_mode_q  <= 1'b0;
            stand_by_q <= 1'b1;
            req_q      <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= addr_of('0);
          end
        end

        BK_SEL: begin
          if (dirty[idx_q]) begin
            bk_ens_q <= onehot(idx_q);
            req_q    <= 1'b1;
            we_q     <= 1'b1;
            addr_q   <= addr_of(idx_q);
            wdata_q  <= bk_slice[idx_q];
            state_q  <= BK_WR;
          end else if (idx_q == LAST) begin
            state_q   <= DONE;
            bk_done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        // request, address and data are left untouched until the ack
        BK_WR: begin
          if (nvm_ack) begin
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            bk_ens_q  <= '0;
            bk_acks_q <= onehot(idx_q);
            state_q   <= BK_ACK;
          end
        end

        BK_ACK: begin
          if (idx_q == LAST) begin
            state_q   <= DONE;
            bk_done_q <= 1'b1;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= BK_SEL;
          end
        end

        // an abort never drops an outstanding read; it is acted on at the ack
        RS_RD: begin
          if (Pwr_warn) abort_q <= 1'b1;
          if (nvm_ack) begin
            req_q <= 1'b0;
            if (abort_now) begin
              state_q   <= BK_SEL;
              idx_q     <= '0;
              bk_mode_q <= 1'b1;
              abort_q   <= 1'b0;
            end else begin
              rs_vins_q <= {N_REGS{nvm_rdata}};
              rs_ens_q  <= onehot(idx_q);
              state_q   <= RS_APPLY;
            end
          end
        end

        RS_APPLY: begin
          if (abort_now) begin
            state_q   <= BK_SEL;
            idx_q     <= '0;
            bk_mode_q <= 1'b1;
            abort_q   <= 1'b0;
          end else if (idx_q == LAST) begin
            state_q   <= DONE;
            rs_done_q <= 1'b1;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= RS_RD;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= addr_of(idx_q + 1'b1);
          end
        end

        // hold the done flag until the originating request is released
        DONE: begin
          if (bk_mode_q ? !Pwr_warn : !Restore_req) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            stand_by_q <= 1'b0;
            bk_done_q  <= 1'b0;
            rs_done_q  <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign backup_ens_cu   = bk_ens_q;
  assign backup_acks_cu  = bk_acks_q;
  assign restore_ens_cu  = rs_ens_q;
  assign restore_Vins_cu = rs_vins_q;
  assign nvm_req         = req_q;
  assign nvm_we          = we_q;
  assign nvm_addr        = addr_q;
  assign nvm_wdata       = wdata_q;
  assign stand_by        = stand_by_q;
  assign Bk_done         = bk_done_q;
  assign Rs_done         = rs_done_q;

endmodule

// File: tb/tb_cu_backup_ctrl.sv
// Directed bench for cu_backup_ctrl with a small NVM responder (ack two
// cycles after a request) that also watches request/address/data stability.
module tb_cu_backup_ctrl;
  localparam int N = 3, W = 32, AW = 8;

  logic Clk = 1'b0, Rst = 1'b0, Pwr_warn = 1'b0, Restore_req = 1'b0;
  logic [2*N-1:0] dirty_vals_cu = '0;
  logic [W*N-1:0] backup_Vouts_cu = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
  logic [N-1:0]   backup_ens_cu, backup_acks_cu, restore_ens_cu;
  logic [W*N-1:0] restore_Vins_cu;
  logic           nvm_req, nvm_we, nvm_ack = 1'b0;
  logic [AW-1:0]  nvm_addr;
  logic [W-1:0]   nvm_wdata, nvm_rdata = '0;
  logic           stand_by, Bk_done, Rs_done;

  int errors = 0, checks = 0;

  cu_backup_ctrl #(.N_REGS(N), .W(W), .AW(AW), .BASE_ADDR(0)) dut (
    .Clk(Clk), .Rst(Rst), .Pwr_warn(Pwr_warn), .Restore_req(Restore_req),
    .dirty_vals_cu(dirty_vals_cu), .backup_Vouts_cu(backup_Vouts_cu),
    .backup_ens_cu(backup_ens_cu), .backup_acks_cu(backup_acks_cu),
    .restore_ens_cu(restore_ens_cu), .restore_Vins_cu(restore_Vins_cu),
    .nvm_req(nvm_req), .nvm_we(nvm_we), .nvm_addr(nvm_addr),
    .nvm_wdata(nvm_wdata), .nvm_ack(nvm_ack), .nvm_rdata(nvm_rdata),
    .stand_by(stand_by), .Bk_done(Bk_done), .Rs_done(Rs_done)
  );

  always #5 Clk = ~Clk;

  // NVM model
  logic [W-1:0]  mem [4];
  logic [AW-1:0] wr_addr [$];
  logic [W-1:0]  wr_data [$];
  int            req_ticks = 0, wcnt = 0;
  logic          p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [W-1:0]  p_wd = '0;

  always begin
    @(posedge Clk); #1;
    if (Rst && p_req && !p_ack) begin
      checks++;
      if (nvm_req !== 1'b1 || nvm_addr !== p_addr || nvm_we !== p_we || nvm_wdata !== p_wd) begin
        errors++;
        $display("FAIL nvm_hold: req=%b addr=%h we=%b wdata=%h, required req=1 addr=%h we=%b wdata=%h",
                 nvm_req, nvm_addr, nvm_we, nvm_wdata, p_addr, p_we, p_wd);
      end
    end
    nvm_ack = 1'b0;
    if (nvm_req === 1'b1) begin
      req_ticks++;
      if (wcnt >= 1) begin
        nvm_ack   = 1'b1;
        wcnt      = 0;
        nvm_rdata = mem[nvm_addr[1:0]];
        if (nvm_we) begin
          wr_addr.push_back(nvm_addr);
          wr_data.push_back(nvm_wdata);
          mem[nvm_addr[1:0]] = nvm_wdata;
        end
      end else wcnt++;
    end else wcnt = 0;
    p_req = nvm_req; p_ack = nvm_ack; p_we = nvm_we; p_addr = nvm_addr; p_wd = nvm_wdata;
  end

  // observation logs filled by run()
  logic [N-1:0] ack_log [$];
  logic [N-1:0] rs_log [$];
  logic [W-1:0] rs_val [$];
  bit sb_low, ens_bad, vins_bad, arm_abort;

  task automatic tick();
    @(posedge Clk); #2;
  endtask

  task automatic clear_logs();
    ack_log.delete(); rs_log.delete(); rs_val.delete();
    wr_addr.delete(); wr_data.delete();
    sb_low = 0; ens_bad = 0; vins_bad = 0; arm_abort = 0; req_ticks = 0;
  endtask

  // advance until a done flag rises, recording pulses and invariants
  task automatic run(input int maxc, output int cyc);
    cyc = 0;
    while (cyc < maxc && !(Bk_done || Rs_done)) begin
      tick(); cyc++;
      if (backup_acks_cu != 0) ack_log.push_back(backup_acks_cu);
      if (restore_ens_cu != 0) begin
        rs_log.push_back(restore_ens_cu);
        rs_val.push_back(restore_Vins_cu[W-1:0]);
        if (restore_Vins_cu !== {N{restore_Vins_cu[W-1:0]}}) vins_bad = 1;
      end
      if (stand_by !== 1'b1) sb_low = 1;
      if (nvm_req && nvm_we) begin
        if (backup_ens_cu !== (N'(1) << nvm_addr)) ens_bad = 1;
      end else if (backup_ens_cu !== '0) ens_bad = 1;
      if (arm_abort && nvm_req && !nvm_we && nvm_addr == 8'd1) begin
        Pwr_warn = 1'b1; arm_abort = 0;
      end
    end
    if (!(Bk_done || Rs_done)) begin
      errors++; $display("FAIL timeout: no done flag after %0d cycles", maxc);
    end
  endtask

  task automatic check_release(input string nm);
    tick();
    checks++;
    if ({stand_by, Bk_done, Rs_done, nvm_req} !== 4'b0) begin
      errors++;
      $display("FAIL %s_release: stand_by/Bk/Rs/req=%b required 0000", nm, {stand_by, Bk_done, Rs_done, nvm_req});
    end
  endtask

  task automatic test_reset();
    Rst = 1'b0; tick(); tick();
    checks++;
    if ({stand_by, Bk_done, Rs_done} !== 3'b0) begin
      errors++; $display("FAIL reset_flags: %b required 000", {stand_by, Bk_done, Rs_done});
    end
    checks++;
    if ({nvm_req, nvm_we, nvm_addr, nvm_wdata} !== '0) begin
      errors++; $display("FAIL reset_nvm: req=%b we=%b addr=%h wd=%h required 0", nvm_req, nvm_we, nvm_addr, nvm_wdata);
    end
    checks++;
    if ({backup_ens_cu, backup_acks_cu, restore_ens_cu, restore_Vins_cu} !== '0) begin
      errors++; $display("FAIL reset_ens: ens=%b acks=%b rs=%b vins=%h required 0", backup_ens_cu, backup_acks_cu, restore_ens_cu, restore_Vins_cu);
    end
    Rst = 1'b1; tick();
  endtask

  // Case 1: registers 0 and 2 dirty
  task automatic test_backup_dirty();
    int cyc;
    clear_logs(); dirty_vals_cu = 6'b010001; Pwr_warn = 1'b1;
    run(60, cyc);
    checks++;
    if (wr_addr.size() != 2 || wr_addr[0] !== 8'd0 || wr_addr[1] !== 8'd2) begin
      errors++; $display("FAIL bk_addrs: n=%0d a0=%h a1=%h required n=2 00 02", wr_addr.size(), wr_addr[0], wr_addr[1]);
    end
    checks++;
    if (wr_data.size() != 2 || wr_data[0] !== 32'hAAAA0000 || wr_data[1] !== 32'hCCCC0002) begin
      errors++; $display("FAIL bk_data: d0=%h d1=%h required AAAA0000 CCCC0002", wr_data[0], wr_data[1]);
    end
    checks++;
    if (ack_log.size() != 2 || ack_log[0] !== 3'b001 || ack_log[1] !== 3'b100) begin
      errors++; $display("FAIL bk_acks: n=%0d a0=%b a1=%b required n=2 001 100", ack_log.size(), ack_log[0], ack_log[1]);
    end
    checks++;
    if (ens_bad || sb_low) begin
      errors++; $display("FAIL bk_ens_standby: ens_bad=%0d sb_low=%0d required 0 0", ens_bad, sb_low);
    end
    checks++;
    if ({Bk_done, Rs_done} !== 2'b10) begin
      errors++; $display("FAIL bk_done: Bk/Rs=%b required 10", {Bk_done, Rs_done});
    end
    tick();
    checks++;
    if (Bk_done !== 1'b1) begin
      errors++; $display("FAIL bk_done_hold: Bk_done=%b required 1", Bk_done);
    end
    Pwr_warn = 1'b0;
    check_release("bk");
  endtask

  // Case 2: nothing dirty
  task automatic test_backup_clean();
    int cyc;
    clear_logs(); dirty_vals_cu = 6'b101010; Pwr_warn = 1'b1;
    run(20, cyc);
    checks++;
    if (cyc != N + 1) begin
      errors++; $display("FAIL clean_latency: %0d cycles required %0d", cyc, N + 1);
    end
    checks++;
    if (req_ticks != 0 || ack_log.size() != 0) begin
      errors++; $display("FAIL clean_noreq: req_cycles=%0d acks=%0d required 0 0", req_ticks, ack_log.size());
    end
    Pwr_warn = 1'b0;
    check_release("clean");
  endtask

  // Case 3: restore all three registers
  task automatic test_restore();
    int cyc;
    clear_logs();
    mem[0] = 32'hA5A5A5A5; mem[1] = 32'h00007FFF; mem[2] = 32'h1;
    dirty_vals_cu = '0; Restore_req = 1'b1;
    run(60, cyc);
    checks++;
    if (rs_log.size() != 3 || rs_log[0] !== 3'b001 || rs_log[1] !== 3'b010 || rs_log[2] !== 3'b100) begin
      errors++; $display("FAIL rs_order: n=%0d %b %b %b required 3 001 010 100", rs_log.size(), rs_log[0], rs_log[1], rs_log[2]);
    end
    checks++;
    if (rs_val.size() != 3 || rs_val[0] !== 32'hA5A5A5A5 || rs_val[1] !== 32'h00007FFF || rs_val[2] !== 32'h1 || vins_bad) begin
      errors++; $display("FAIL rs_data: %h %h %h bad=%0d required A5A5A5A5 00007FFF 00000001 bad=0", rs_val[0], rs_val[1], rs_val[2], vins_bad);
    end
    checks++;
    if ({Rs_done, Bk_done} !== 2'b10 || wr_addr.size() != 0 || sb_low) begin
      errors++; $display("FAIL rs_done: Rs/Bk=%b writes=%0d sb_low=%0d required 10 0 0", {Rs_done, Bk_done}, wr_addr.size(), sb_low);
    end
    Restore_req = 1'b0;
    check_release("rs");
  endtask

  // Case 4: both requests in the same cycle
  task automatic test_tie();
    int cyc;
    clear_logs(); dirty_vals_cu = 6'b000001;
    Pwr_warn = 1'b1; Restore_req = 1'b1;
    run(60, cyc);
    checks++;
    if ({Bk_done, Rs_done} !== 2'b10 || rs_log.size() != 0) begin
      errors++; $display("FAIL tie_bk: Bk/Rs=%b rs_pulses=%0d required 10 0", {Bk_done, Rs_done}, rs_log.size());
    end
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 8'd0 || ack_log.size() != 1) begin
      errors++; $display("FAIL tie_writes: n=%0d a0=%h acks=%0d required 1 00 1", wr_addr.size(), wr_addr[0], ack_log.size());
    end
    Pwr_warn = 1'b0; Restore_req = 1'b0;
    check_release("tie");
  endtask

  // Case 5: Pwr_warn while register 1 is being restored
  task automatic test_abort();
    int cyc;
    clear_logs();
    mem[0] = 32'hA5A5A5A5; mem[1] = 32'h00007FFF; mem[2] = 32'h1;
    dirty_vals_cu = 6'b000001; Restore_req = 1'b1; arm_abort = 1;
    run(80, cyc);
    checks++;
    if (rs_log.size() < 1 || rs_log[0] !== 3'b001 || rs_val[0] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL abort_first: n=%0d e0=%b v0=%h required >=1 001 A5A5A5A5", rs_log.size(), rs_log[0], rs_val[0]);
    end
    checks++;
    if (rs_log.size() > 2 || (rs_log.size() == 2 && rs_log[1] === 3'b100)) begin
      errors++; $display("FAIL abort_norest: restore pulses=%0d required no pulse for index 2", rs_log.size());
    end
    checks++;
    if ({Bk_done, Rs_done} !== 2'b10) begin
      errors++; $display("FAIL abort_done: Bk/Rs=%b required 10", {Bk_done, Rs_done});
    end
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 8'd0 || wr_data[0] !== 32'hAAAA0000) begin
      errors++; $display("FAIL abort_bk: n=%0d a0=%h d0=%h required 1 00 AAAA0000", wr_addr.size(), wr_addr[0], wr_data[0]);
    end
    Pwr_warn = 1'b0; Restore_req = 1'b0;
    check_release("abort");
  endtask

  // Case 6: reset while a backup write is outstanding
  task automatic test_reset_mid();
    int  cyc = 0;
    bit  sb_bad = 0;
    clear_logs(); dirty_vals_cu = 6'b010001; Pwr_warn = 1'b1;
    while (cyc < 20 && !(nvm_req && nvm_we)) begin
      tick(); cyc++;
      if (stand_by !== 1'b1) sb_bad = 1;
    end
    checks++;
    if (!(nvm_req && nvm_we) || sb_bad) begin
      errors++; $display("FAIL rmid_reach: req=%b we=%b sb_bad=%0d required 1 1 0", nvm_req, nvm_we, sb_bad);
    end
    Rst = 1'b0; tick();
    checks++;
    if ({stand_by, Bk_done, Rs_done, nvm_req, nvm_we, backup_ens_cu, backup_acks_cu, restore_ens_cu} !== '0) begin
      errors++; $display("FAIL rmid_zero: sb=%b bk=%b rs=%b req=%b we=%b ens=%b acks=%b rse=%b required all 0",
                         stand_by, Bk_done, Rs_done, nvm_req, nvm_we, backup_ens_cu, backup_acks_cu, restore_ens_cu);
    end
    Pwr_warn = 1'b0; Rst = 1'b1; tick();
    checks++;
    if ({stand_by, nvm_req} !== 2'b00) begin
      errors++; $display("FAIL rmid_idle: stand_by=%b req=%b required 0 0", stand_by, nvm_req);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    test_reset();
    test_backup_dirty();
    test_backup_clean();
    test_restore();
    test_tie();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
